// File: rtl/brk_sequencer.sv
// 6502 interrupt/reset sequencer: NMI edge detect, IRQ/BRK/RESET acceptance at
// opcode fetch, and the seven-cycle vector sequence with its dispatch strobes.
module brk_sequencer (
    input  logic       PHI0,
    input  logic       RES,
    input  logic       n_RESIN,
    input  logic       n_NMI,
    input  logic       n_IRQ,
    input  logic       I_FLAG,
    input  logic       RDY,
    input  logic       T1,
    input  logic       BRK_OP,
    output logic       B_OUT,
    output logic       BRK6E,
    output logic       BRK7,
    output logic       RESP,
    output logic       DORES,
    output logic       B_FLAG,
    output logic       I_SET,
    output logic [7:0] ZADL,
    output logic [2:0] SEQ
);
    // C1..C7 encode their own cycle number so SEQ is a direct slice
    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_C1   = 4'd1;
    localparam logic [3:0] S_C2   = 4'd2;
    localparam logic [3:0] S_C3   = 4'd3;
    localparam logic [3:0] S_C4   = 4'd4;
    localparam logic [3:0] S_C5   = 4'd5;
    localparam logic [3:0] S_C6   = 4'd6;
    localparam logic [3:0] S_C7   = 4'd7;
    localparam logic [3:0] S_HOLD = 4'd8;

    localparam logic [1:0] SRC_RST = 2'd0;
    localparam logic [1:0] SRC_NMI = 2'd1;
    localparam logic [1:0] SRC_IRQ = 2'd2;
    localparam logic [1:0] SRC_BRK = 2'd3;

    logic [3:0] state;
    logic [1:0] src;
    logic       nmi_prev;
    logic       nmi_pend;
    logic       nmi_edge;
    logic       nmi_clr;
    logic       irq_req;
    logic       is_idle;
    logic [7:0] vec_lo;

    assign nmi_edge = nmi_prev & ~n_NMI;
    assign irq_req  = ~n_IRQ & ~I_FLAG;
    assign nmi_clr  = (state == S_C6) & n_RESIN & RDY & (src == SRC_NMI);
    assign is_idle  = (state == S_IDLE);

    always_ff @(posedge PHI0) begin
        if (RES) begin
            state    <= S_IDLE;
            src      <= SRC_IRQ;
            nmi_pend <= 1'b0;
            nmi_prev <= 1'b1;
        end else begin
            nmi_prev <= n_NMI;
            // a fresh edge on the clearing edge must survive the clear
            nmi_pend <= (nmi_pend & ~nmi_clr) | nmi_edge;
            if (!n_RESIN) begin
                state <= S_HOLD;
            end else if (state == S_HOLD) begin
                state <= S_C1;
                src   <= SRC_RST;
            end else if (RDY) begin
                case (state)
                    S_IDLE: begin
                        if (T1) begin
                            if (nmi_pend) begin
                                state <= S_C2;
                                src   <= SRC_NMI;
                            end else if (irq_req) begin
                                state <= S_C2;
                                src   <= SRC_IRQ;
                            end else if (BRK_OP) begin
                                state <= S_C2;
                                src   <= SRC_BRK;
                            end
                        end
                    end
                    S_C1, S_C2, S_C3, S_C4, S_C5, S_C6: state <= state + 4'd1;
                    default: state <= S_IDLE;
                endcase
                // IRQ/BRK redirected to the NMI vector if an NMI arrives by C5
                if (state == S_C5 && src[1] && (nmi_pend | nmi_edge))
                    src <= SRC_NMI;
            end
        end
    end

    always_comb begin
        vec_lo = 8'hFE;
        if (src == SRC_NMI)      vec_lo = 8'hFA;
        else if (src == SRC_RST) vec_lo = 8'hFC;
    end

    assign B_OUT  = (state == S_C1) | (is_idle & T1 & RDY & (nmi_pend | irq_req));
    assign RESP   = (state == S_HOLD) | (state == S_C1);
    assign DORES  = (src == SRC_RST) & (state == S_C3 || state == S_C4 || state == S_C5);
    assign B_FLAG = (src == SRC_BRK) & (state == S_C5);
    assign BRK6E  = (state == S_C6);
    assign BRK7   = (state == S_C7);
    assign I_SET  = (state == S_C6);
    assign ZADL   = BRK6E ? vec_lo : (BRK7 ? (vec_lo | 8'h01) : 8'h00);
    assign SEQ    = state[3] ? 3'd0 : state[2:0];
endmodule

// File: tb/tb_brk_sequencer.sv
// Directed bench for brk_sequencer: each task drives one scenario and
// compares the packed output vector cycle by cycle against hand-built values.
module tb_brk_sequencer;
    logic       PHI0 = 1'b0;
    logic       RES, n_RESIN, n_NMI, n_IRQ, I_FLAG, RDY, T1, BRK_OP;
    logic       B_OUT, BRK6E, BRK7, RESP, DORES, B_FLAG, I_SET;
    logic [7:0] ZADL;
    logic [2:0] SEQ;
    logic [17:0] obs;
    int errors = 0;
    int checks = 0;

    brk_sequencer dut (
        .PHI0(PHI0), .RES(RES), .n_RESIN(n_RESIN), .n_NMI(n_NMI), .n_IRQ(n_IRQ),
        .I_FLAG(I_FLAG), .RDY(RDY), .T1(T1), .BRK_OP(BRK_OP),
        .B_OUT(B_OUT), .BRK6E(BRK6E), .BRK7(BRK7), .RESP(RESP), .DORES(DORES),
        .B_FLAG(B_FLAG), .I_SET(I_SET), .ZADL(ZADL), .SEQ(SEQ)
    );

    always #5 PHI0 = ~PHI0;

    assign obs = {B_OUT, BRK6E, BRK7, RESP, DORES, B_FLAG, I_SET, ZADL, SEQ};

    function automatic logic [17:0] mk(logic bo, logic b6, logic b7, logic rp, logic dr,
                                       logic bf, logic is, logic [7:0] z, logic [2:0] s);
        return {bo, b6, b7, rp, dr, bf, is, z, s};
    endfunction

    // expected outputs in sequence cycle n for vector low byte zv
    function automatic logic [17:0] seq_exp(int n, logic [7:0] zv, logic rst_src, logic bf);
        case (n)
            1: return mk(1, 0, 0, 1, 0, 0, 0, 8'h00, 3'd1);
            2: return mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 3'd2);
            3: return mk(0, 0, 0, 0, rst_src, 0, 0, 8'h00, 3'd3);
            4: return mk(0, 0, 0, 0, rst_src, 0, 0, 8'h00, 3'd4);
            5: return mk(0, 0, 0, 0, rst_src, bf, 0, 8'h00, 3'd5);
            6: return mk(0, 1, 0, 0, 0, 0, 1, zv, 3'd6);
            7: return mk(0, 0, 1, 0, 0, 0, 0, zv + 8'h01, 3'd7);
            default: return 18'h0;
        endcase
    endfunction

    task automatic tick();
        @(posedge PHI0);
        #1;
    endtask

    task automatic test_reset();
        RES = 1; n_RESIN = 1; n_NMI = 1; n_IRQ = 1; I_FLAG = 0;
        RDY = 1; T1 = 0; BRK_OP = 0;
        tick(); tick();
        checks++;
        if (obs !== 18'h0) begin errors++; $display("FAIL reset_outs got %h exp %h", obs, 18'h0); end
        RES = 0; T1 = 1; #1;
        checks++;
        if (B_OUT !== 1'b0) begin errors++; $display("FAIL reset_no_pend got %b exp 0", B_OUT); end
        T1 = 0; n_RESIN = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs !== mk(0, 0, 0, 1, 0, 0, 0, 8'h00, 3'd0)) begin
                errors++; $display("FAIL hold_%0d got %h exp %h", i, obs, mk(0, 0, 0, 1, 0, 0, 0, 8'h00, 3'd0));
            end
        end
        n_RESIN = 1;
        for (int n = 1; n <= 8; n++) begin
            tick();
            checks++;
            if (obs !== seq_exp(n, 8'hFC, 1, 0)) begin
                errors++; $display("FAIL rst_seq_c%0d got %h exp %h", n, obs, seq_exp(n, 8'hFC, 1, 0));
            end
        end
    endtask

    task automatic test_irq();
        n_IRQ = 0; I_FLAG = 0; T1 = 1; #1;
        checks++;
        if (obs !== mk(1, 0, 0, 0, 0, 0, 0, 8'h00, 3'd0)) begin
            errors++; $display("FAIL irq_accept got %h exp %h", obs, mk(1, 0, 0, 0, 0, 0, 0, 8'h00, 3'd0));
        end
        tick();
        T1 = 0; n_IRQ = 1;  // deassertion mid-sequence must not matter
        for (int n = 2; n <= 8; n++) begin
            checks++;
            if (obs !== seq_exp(n, 8'hFE, 0, 0)) begin
                errors++; $display("FAIL irq_seq_c%0d got %h exp %h", n, obs, seq_exp(n, 8'hFE, 0, 0));
            end
            tick();
        end
        n_IRQ = 0; I_FLAG = 1; T1 = 1; #1;
        checks++;
        if (obs !== 18'h0) begin errors++; $display("FAIL irq_masked_bout got %h exp %h", obs, 18'h0); end
        tick();
        checks++;
        if (obs !== 18'h0) begin errors++; $display("FAIL irq_masked_seq got %h exp %h", obs, 18'h0); end
        n_IRQ = 1; I_FLAG = 0; T1 = 0;
        tick();
    endtask

    task automatic test_brk();
        T1 = 1; BRK_OP = 1; #1;
        checks++;
        if (obs !== 18'h0) begin errors++; $display("FAIL brk_no_bout got %h exp %h", obs, 18'h0); end
        tick();
        T1 = 0; BRK_OP = 0;
        for (int n = 2; n <= 8; n++) begin
            checks++;
            if (obs !== seq_exp(n, 8'hFE, 0, 1)) begin
                errors++; $display("FAIL brk_seq_c%0d got %h exp %h", n, obs, seq_exp(n, 8'hFE, 0, 1));
            end
            tick();
        end
    endtask

    task automatic test_hijack();
        T1 = 1; BRK_OP = 1;
        tick();
        T1 = 0; BRK_OP = 0;
        for (int n = 2; n <= 8; n++) begin
            checks++;
            if (obs !== seq_exp(n, 8'hFA, 0, 1)) begin
                errors++; $display("FAIL hijack_c%0d got %h exp %h", n, obs, seq_exp(n, 8'hFA, 0, 1));
            end
            if (n == 4) n_NMI = 0;
            if (n == 6) n_NMI = 1;
            tick();
        end
        T1 = 1; #1;
        checks++;
        if (B_OUT !== 1'b0) begin errors++; $display("FAIL hijack_pend_clr got %b exp 0", B_OUT); end
        T1 = 0;
        tick();
    endtask

    task automatic test_nmi_priority();
        n_NMI = 0;
        tick();
        n_NMI = 1; n_IRQ = 0; T1 = 1; #1;
        checks++;
        if (B_OUT !== 1'b1) begin errors++; $display("FAIL prio_bout got %b exp 1", B_OUT); end
        tick();
        T1 = 0; n_IRQ = 1;
        for (int n = 2; n <= 8; n++) begin
            checks++;
            if (obs !== seq_exp(n, 8'hFA, 0, 0)) begin
                errors++; $display("FAIL prio_c%0d got %h exp %h", n, obs, seq_exp(n, 8'hFA, 0, 0));
            end
            if (n == 6) n_NMI = 0;
            if (n == 7) n_NMI = 1;
            tick();
        end
        T1 = 1; #1;
        checks++;
        if (B_OUT !== 1'b1) begin errors++; $display("FAIL second_nmi_bout got %b exp 1", B_OUT); end
        tick();
        T1 = 0;
        for (int n = 2; n <= 8; n++) begin
            checks++;
            if (obs !== seq_exp(n, 8'hFA, 0, 0)) begin
                errors++; $display("FAIL second_nmi_c%0d got %h exp %h", n, obs, seq_exp(n, 8'hFA, 0, 0));
            end
            tick();
        end
    endtask

    task automatic test_rdy_and_abort();
        T1 = 1; BRK_OP = 1;
        tick();
        T1 = 0; BRK_OP = 0;
        tick();
        RDY = 0;
        for (int i = 0; i < 3; i++) begin
            n_NMI = (i == 1) ? 1'b0 : 1'b1;  // NMI edge taken while stalled
            tick();
            checks++;
            if (obs !== seq_exp(3, 8'hFE, 0, 0)) begin
                errors++; $display("FAIL rdy_hold_%0d got %h exp %h", i, obs, seq_exp(3, 8'hFE, 0, 0));
            end
        end
        n_NMI = 1; RDY = 1;
        tick();
        checks++;
        if (obs !== seq_exp(4, 8'hFE, 0, 0)) begin
            errors++; $display("FAIL rdy_resume got %h exp %h", obs, seq_exp(4, 8'hFE, 0, 0));
        end
        n_RESIN = 0;
        tick();
        checks++;
        if (obs !== mk(0, 0, 0, 1, 0, 0, 0, 8'h00, 3'd0)) begin
            errors++; $display("FAIL abort_hold got %h exp %h", obs, mk(0, 0, 0, 1, 0, 0, 0, 8'h00, 3'd0));
        end
        n_RESIN = 1;
        for (int n = 1; n <= 8; n++) begin
            tick();
            checks++;
            if (obs !== seq_exp(n, 8'hFC, 1, 0)) begin
                errors++; $display("FAIL abort_rst_c%0d got %h exp %h", n, obs, seq_exp(n, 8'hFC, 1, 0));
            end
        end
        T1 = 1; #1;
        checks++;
        if (B_OUT !== 1'b1) begin errors++; $display("FAIL pend_kept_bout got %b exp 1", B_OUT); end
        tick();
        T1 = 0;
        for (int n = 2; n <= 8; n++) begin
            checks++;
            if (obs !== seq_exp(n, 8'hFA, 0, 0)) begin
                errors++; $display("FAIL pend_kept_c%0d got %h exp %h", n, obs, seq_exp(n, 8'hFA, 0, 0));
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_irq();
        test_brk();
        test_hijack();
        test_nmi_priority();
        test_rdy_and_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/brk_sequencer.md
# brk_sequencer

Single-clock interrupt and reset sequencer for the 6502 core. It detects NMI edges, samples IRQ level and the reset pin, and decides at each opcode fetch whether to force a BRK. It then steps the seven-cycle BRK/IRQ/NMI/RESET sequence. It drives the B_OUT, BRK6E, RESP and DORES strobes consumed by the dispatch logic, plus the vector address low byte for the ADL bus.

## Interface
Parameters: none.

- PHI0  in  1  CPU clock; one rising edge per CPU cycle
- RES  in  1  synchronous, active-high block reset
- n_RESIN  in  1  CPU reset pin, active-low, sampled every edge
- n_NMI  in  1  NMI pin, falling-edge sensitive
- n_IRQ  in  1  IRQ pin, active-low level
- I_FLAG  in  1  interrupt-disable flag from the P register
- RDY  in  1  1 = cycle advances; 0 = sequence state frozen
- T1  in  1  current cycle is an opcode fetch (from dispatch)
- BRK_OP  in  1  predecoded opcode 0x00 on the data bus during T1
- B_OUT  out  1  force IR to 0x00 (hardware interrupt/reset fetch)
- BRK6E  out  1  sequence cycle 6 (vector low fetch)
- BRK7  out  1  sequence cycle 7 (vector high fetch)
- RESP  out  1  reset in progress
- DORES  out  1  suppress writes (stack pushes become reads) during the reset sequence
- B_FLAG  out  1  value of the B bit pushed in cycle 5
- I_SET  out  1  set I flag
- ZADL  out  8  vector address low byte, 0x00 when not in C6/C7
- SEQ  out  3  current cycle: 0 = idle, 1..7 = sequence cycle

## Operation
- States:
  - IDLE
  - HOLD (reset pin asserted)
  - C1: forced fetch, used only after reset
  - C2..C7
- Registers:
  - state
  - src ∈ {RST, NMI, IRQ, BRK}
  - nmi_prev
  - nmi_pend
- NMI detect runs every edge, independent of RDY and state:
  - nmi_pend <= nmi_pend | (nmi_prev & ~n_NMI)
  - nmi_prev <= n_NMI
- irq_req = ~n_IRQ & ~I_FLAG (combinational, level).
- Transitions, first match wins:
  - n_RESIN=0 → HOLD from any state; RDY is ignored.
  - In HOLD with n_RESIN=1 → C1, src=RST.
  - RDY=0 → stay; all registered state is held.
  - In IDLE with T1=1, RDY=1, source selection by priority:
    - nmi_pend → C2, src=NMI
    - else irq_req → C2, src=IRQ
    - else BRK_OP → C2, src=BRK
    - else stay IDLE
  - Cn → Cn+1 for n = 1..6; C7 → IDLE.
- Hijack: on the edge leaving C5, if src ∈ {IRQ, BRK} and nmi_pend=1, src <= NMI.
- nmi_pend is cleared on the edge leaving C6 when src=NMI. A new NMI edge sampled on that same edge wins, so nmi_pend stays 1.
- Combinational outputs:
  - B_OUT = (state==C1) | (IDLE & T1 & RDY & (nmi_pend | irq_req))
  - software BRK never asserts B_OUT
  - RESP = HOLD | C1
  - DORES = src==RST & state ∈ {C3, C4, C5}
  - B_FLAG = src==BRK & state==C5; otherwise 0
  - BRK6E = C6; BRK7 = C7; I_SET = C6 (all sources)
  - ZADL in C6: 0xFA (NMI), 0xFC (RST), 0xFE (IRQ/BRK)
  - ZADL in C7: the C6 value + 1; 0x00 in all other states
  - SEQ = cycle number; 0 in IDLE and HOLD
- RES=1: state=IDLE, src=IRQ, nmi_pend=0, nmi_prev=1. All outputs are 0 except B_OUT, which follows its equation.

## Timing
- All outputs are valid in the same cycle as the state they decode. B_OUT is combinational on T1/RDY/pending, so its valid time is set by the T1 path.
- A hardware interrupt accepted at T1 in cycle k gives C2 at k+1, C6 (BRK6E) at k+5, C7 at k+6, and IDLE at k+7.
- NMI latency: n_NMI low sampled at edge e sets nmi_pend after e. It is accepted at the first IDLE & T1 & RDY after that.
- Hijack window: an NMI edge sampled on or before the edge leaving C5 redirects the vector. An edge sampled while in C6 or C7 stays pending for the next T1.
- IRQ is level-sampled only at acceptance. Deassertion during the sequence has no effect.
- RDY=0 in any Cn holds SEQ and all outputs stable. NMI detection continues while RDY=0.
- Reset pin low mid-sequence aborts to HOLD on the next edge. nmi_pend is preserved.

## Test plan
- RES=1 for 2 cycles → SEQ=0, all outputs 0, no pending NMI. Then n_RESIN low 3 cycles → RESP=1, SEQ=0. Release → C1 with B_OUT=1, RESP=1; DORES=1 at SEQ 3..5; ZADL=0xFC at SEQ 6 and 0xFD at SEQ 7; IDLE after.
- n_IRQ=0, I_FLAG=0, T1=1, RDY=1 in IDLE → B_OUT=1 that cycle; SEQ 2..7 follows; B_FLAG=0 at C5; ZADL 0xFE/0xFF; I_SET=1 at C6. Repeat with I_FLAG=1 → no response.
- T1=1, BRK_OP=1, no interrupt pending → B_OUT=0; B_FLAG=1 at C5; ZADL=0xFE at C6.
- Software BRK accepted, NMI falling edge at C4 → B_FLAG=1 at C5; ZADL=0xFA at C6, 0xFB at C7; nmi_pend=0 after C6.
- NMI pending and IRQ active at the same T1 → src=NMI, ZADL=0xFA. A second NMI edge at C6 → serviced at the next T1 after IDLE.
- RDY=0 for 3 cycles at C3 → SEQ stays 3, outputs stable. n_RESIN low at C4 → HOLD next cycle, RESP=1.
